synth_i2s_tx: RTL and testbench
===============================

# synth_i2s_tx

Audio serializer directly downstream of the synth clock generator. It takes one stereo sample pair per frame from the voice/mix engine through a ready/valid handshake, double-buffers it, and shifts it out MSB-first in I2S format. Bit timing comes from the generator's LRCK and BCK outputs, which the block samples and edge-detects in the OSC_CLK domain. Its serial output drives the codec DAC data pin.

## Interface
- DATA_WIDTH, 16, bits per channel sample
- CNT_WIDTH, 6, width of the per-channel BCK edge counter; it saturates, never wraps
- OSC_CLK  in  1  system clock, 180.555556 MHz; all logic on posedge
- iRST  in  1  reset; synchronous, active-high
- iLRCK  in  1  word clock from the clock generator; asynchronous to OSC_CLK; low = left
- iBCK  in  1  bit clock from the clock generator; asynchronous to OSC_CLK
- iSAMPLE_L  in  DATA_WIDTH  left sample, two's complement
- iSAMPLE_R  in  DATA_WIDTH  right sample, two's complement
- iSAMPLE_VALID  in  1  sample pair offered
- oSAMPLE_READY  out  1  holding buffer empty; transfer when VALID & READY
- oAUD_DATA  out  1  I2S serial data
- oFRAME_STROBE  out  1  one-cycle pulse at each left-frame start
- oUNDERRUN  out  1  sticky flag: a frame started with an empty holding buffer
- iUNDERRUN_CLR  in  1  clears oUNDERRUN

## Operation
- Synchronizers: iLRCK and iBCK each pass through 2 flops, then a history flop for edge detection.
  - lr_fall / lr_rise: one-cycle pulses.
  - bck_fall: one-cycle pulse.
- Holding buffer: one L/R pair plus a hold_full bit.
  - oSAMPLE_READY = !hold_full.
  - On accept, the pair is captured and hold_full is set.
- FSM states:
  - IDLE → LEFT on lr_fall.
  - LEFT → RIGHT on lr_rise.
  - RIGHT → LEFT on lr_fall.
  - lr_rise in IDLE is ignored. This covers iLRCK being high when reset releases.
- Left-frame start (lr_fall in IDLE or RIGHT):
  - Pulse oFRAME_STROBE.
  - If hold_full: copy the holding pair into the active pair and clear hold_full.
  - Else: keep the previous active pair (zero after reset) and set oUNDERRUN.
  - Load the shifter with active L and clear bit_cnt.
- Right-frame start (lr_rise in LEFT): load the shifter with active R and clear bit_cnt.
- Simultaneous events at a left-frame start:
  - Transfer uses hold_full as it stood before that cycle.
  - A pair accepted in the same cycle goes into the holding buffer and is used next frame. Underrun is still flagged.
- oUNDERRUN precedence: a set in the same cycle as iUNDERRUN_CLR wins.
- Per bck_fall in LEFT/RIGHT (bit_cnt increments, saturating at all-ones):
  - bit_cnt 0: I2S one-bit delay slot; oAUD_DATA = 0.
  - bit_cnt 1..DATA_WIDTH: oAUD_DATA = shifter MSB, then shift left and zero-fill.
  - bit_cnt above DATA_WIDTH: oAUD_DATA = 0 (padding).
- A bck_fall in the same cycle as an LRCK edge is processed after the load. It is the delay slot of the new channel.
- In IDLE, oAUD_DATA = 0.

## Timing
- Reset values:
  - oAUD_DATA = 0, oFRAME_STROBE = 0, oUNDERRUN = 0.
  - oSAMPLE_READY = 1 (hold_full = 0).
  - FSM = IDLE; all synchronizer flops, active pair, shifter and bit_cnt = 0.
- Reset asserted mid-frame: everything returns to the reset values on the next clock edge. No partial word resumes.
- Latency: pin edge → internal pulse takes 3 OSC_CLK cycles. oAUD_DATA updates on the clock edge after the pulse, so 4 cycles from the pin edge.
- Handshake:
  - The source holds iSAMPLE_* stable while VALID is high and READY is low.
  - oSAMPLE_READY falls one cycle after an accept and rises one cycle after the left-frame-start transfer.
- Throughput: one pair per LRCK period.
- The block works with any BCK period of at least 8 OSC_CLK cycles. The generator's BCK is about 64 cycles.

## Test plan
- Reset, then L=16'hA5C3, R=16'h0F0F, then 2 LRCK frames → left word reads delay 0, bits 1010010111000011, then zeros; right word reads delay 0, 0000111100001111; oUNDERRUN = 0.
- No sample offered before the second lr_fall → the previous pair is re-sent, oUNDERRUN = 1. It stays 1 until iUNDERRUN_CLR, which clears it the next cycle.
- VALID asserted in the same cycle as the lr_fall pulse with the buffer empty → underrun flagged; the pair (16'h1234 / 16'h8001) appears in the following frame; READY = 0 until then.
- iLRCK high at reset release, then rising and falling edges → the first lr_rise is ignored and the first strobe comes on lr_fall; oAUD_DATA stays 0 before that.
- iRST asserted at left bit 7 → all outputs return to reset values on the next clock. After release, output restarts cleanly at the next lr_fall with the new buffered pair.
- bck_fall coincident with lr_fall → that edge is the delay slot (0) and the MSB appears on the next bck_fall.

Source files
------------

// File: rtl/synth_i2s_tx.sv
// I2S transmitter: double-buffered stereo sample pair serialized MSB-first
// using LRCK/BCK edges recovered from the clock generator in the OSC_CLK domain.
module synth_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  OSC_CLK,
  input  logic                  iRST,
  input  logic                  iLRCK,
  input  logic                  iBCK,
  input  logic [DATA_WIDTH-1:0] iSAMPLE_L,
  input  logic [DATA_WIDTH-1:0] iSAMPLE_R,
  input  logic                  iSAMPLE_VALID,
  output logic                  oSAMPLE_READY,
  output logic                  oAUD_DATA,
  output logic                  oFRAME_STROBE,
  output logic                  oUNDERRUN,
  input  logic                  iUNDERRUN_CLR
);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  state_t state;
  state_t state_next;

  logic lrck_sync1;
  logic lrck_sync2;
  logic lrck_hist;
  logic bck_sync1;
  logic bck_sync2;
  logic bck_hist;
  logic lr_fall;
  logic lr_rise;
  logic bck_fall;

  logic [DATA_WIDTH-1:0] hold_l;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] active_l;
  logic [DATA_WIDTH-1:0] active_r;
  logic [DATA_WIDTH-1:0] shifter;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CNT_WIDTH-1:0]  bit_cnt_inc;
  logic                  aud_data;
  logic                  frame_strobe;
  logic                  underrun;

  logic                  left_start;
  logic                  right_start;
  logic                  accept;
  logic [DATA_WIDTH-1:0] load_word;

  // Edge pulses are registered so the pin-to-pulse delay is three cycles.
  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      lrck_sync1 <= 1'b0;
      lrck_sync2 <= 1'b0;
      lrck_hist  <= 1'b0;
      bck_sync1  <= 1'b0;
      bck_sync2  <= 1'b0;
      bck_hist   <= 1'b0;
      lr_fall    <= 1'b0;
      lr_rise    <= 1'b0;
      bck_fall   <= 1'b0;
    end else begin
      lrck_sync1 <= iLRCK;
      lrck_sync2 <= lrck_sync1;
      lrck_hist  <= lrck_sync2;
      bck_sync1  <= iBCK;
      bck_sync2  <= bck_sync1;
      bck_hist   <= bck_sync2;
      lr_fall    <= lrck_hist & ~lrck_sync2;
      lr_rise    <= ~lrck_hist & lrck_sync2;
      bck_fall   <= bck_hist & ~bck_sync2;
    end
  end

  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A rising LRCK seen from IDLE is dropped so output always starts on a left word.
  always_comb begin
    state_next  = state;
    left_start  = 1'b0;
    right_start = 1'b0;
    case (state)
      IDLE: begin
        if (lr_fall) begin
          state_next = LEFT;
          left_start = 1'b1;
        end
      end
      LEFT: begin
        if (lr_rise) begin
          state_next  = RIGHT;
          right_start = 1'b1;
        end
      end
      RIGHT: begin
        if (lr_fall) begin
          state_next = LEFT;
          left_start = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    accept = iSAMPLE_VALID & ~hold_full;
    if (left_start) begin
      load_word = hold_full ? hold_l : active_l;
    end else begin
      load_word = active_r;
    end
    if (bit_cnt == '1) begin
      bit_cnt_inc = bit_cnt;
    end else begin
      bit_cnt_inc = bit_cnt + CNT_WIDTH'(1);
    end
  end

  // A pair accepted on a left-frame start lands in the holding buffer for the next frame.
  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      hold_l       <= '0;
      hold_r       <= '0;
      hold_full    <= 1'b0;
      active_l     <= '0;
      active_r     <= '0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= left_start;
      if (accept) begin
        hold_l <= iSAMPLE_L;
        hold_r <= iSAMPLE_R;
      end
      if (accept) begin
        hold_full <= 1'b1;
      end else if (left_start) begin
        hold_full <= 1'b0;
      end
      if (left_start && hold_full) begin
        active_l <= hold_l;
        active_r <= hold_r;
      end
      if (left_start && !hold_full) begin
        underrun <= 1'b1;
      end else if (iUNDERRUN_CLR) begin
        underrun <= 1'b0;
      end
    end
  end

  // A BCK fall coinciding with a channel load becomes that channel's delay slot.
  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      shifter  <= '0;
      bit_cnt  <= '0;
      aud_data <= 1'b0;
    end else if (left_start || right_start) begin
      shifter <= load_word;
      if (bck_fall) begin
        bit_cnt  <= CNT_WIDTH'(1);
        aud_data <= 1'b0;
      end else begin
        bit_cnt <= '0;
      end
    end else if (state == IDLE) begin
      aud_data <= 1'b0;
    end else if (bck_fall) begin
      bit_cnt <= bit_cnt_inc;
      if (bit_cnt == '0) begin
        aud_data <= 1'b0;
      end else if (bit_cnt <= CNT_WIDTH'(DATA_WIDTH)) begin
        aud_data <= shifter[DATA_WIDTH-1];
        shifter  <= {shifter[DATA_WIDTH-2:0], 1'b0};
      end else begin
        aud_data <= 1'b0;
      end
    end
  end

  assign oSAMPLE_READY = ~hold_full;
  assign oAUD_DATA     = aud_data;
  assign oFRAME_STROBE = frame_strobe;
  assign oUNDERRUN     = underrun;

endmodule

// File: tb/tb_synth_i2s_tx.sv
// Directed bench for synth_i2s_tx: drives LRCK/BCK directly and compares
// each captured channel word against hand-computed I2S bit patterns.
module tb_synth_i2s_tx;

  logic        OSC_CLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iLRCK = 1'b0;
  logic        iBCK = 1'b1;
  logic [15:0] iSAMPLE_L = '0;
  logic [15:0] iSAMPLE_R = '0;
  logic        iSAMPLE_VALID = 1'b0;
  logic        oSAMPLE_READY;
  logic        oAUD_DATA;
  logic        oFRAME_STROBE;
  logic        oUNDERRUN;
  logic        iUNDERRUN_CLR = 1'b0;

  int assertCount = 0;
  int failCount = 0;
  int strobeCount = 0;
  int strobeBase = 0;
  logic [19:0] word;

  synth_i2s_tx #(.DATA_WIDTH(16), .CNT_WIDTH(6)) dut (
    .OSC_CLK(OSC_CLK),
    .iRST(iRST),
    .iLRCK(iLRCK),
    .iBCK(iBCK),
    .iSAMPLE_L(iSAMPLE_L),
    .iSAMPLE_R(iSAMPLE_R),
    .iSAMPLE_VALID(iSAMPLE_VALID),
    .oSAMPLE_READY(oSAMPLE_READY),
    .oAUD_DATA(oAUD_DATA),
    .oFRAME_STROBE(oFRAME_STROBE),
    .oUNDERRUN(oUNDERRUN),
    .iUNDERRUN_CLR(iUNDERRUN_CLR)
  );

  always #5 OSC_CLK = ~OSC_CLK;

  // Frame strobes are counted on the falling edge, away from the update edge.
  always @(negedge OSC_CLK) begin
    if (oFRAME_STROBE) strobeCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
    int waitCnt;
    waitCnt = 0;
    while (!oSAMPLE_READY && waitCnt < 2000) begin
      @(negedge OSC_CLK);
      waitCnt++;
    end
    checkOutput("ready_wait", 32'(oSAMPLE_READY), 32'd1);
    iSAMPLE_L = l;
    iSAMPLE_R = r;
    iSAMPLE_VALID = 1'b1;
    @(negedge OSC_CLK);
    iSAMPLE_VALID = 1'b0;
  endtask

  // One channel of BCK periods (16 OSC cycles each); LRCK moves with the first BCK fall.
  // With offer set, VALID is raised exactly while the resulting lr pulse is live.
  task automatic sendChannel(input logic lr, input int nPeriods, input logic offer,
                             input logic [15:0] offerL, input logic [15:0] offerR,
                             output logic [19:0] bits);
    bits = '0;
    for (int p = 0; p < nPeriods; p++) begin
      iBCK = 1'b0;
      if (p == 0) iLRCK = lr;
      for (int i = 0; i < 8; i++) begin
        @(negedge OSC_CLK);
        if (offer && p == 0 && i == 2) begin
          iSAMPLE_L = offerL;
          iSAMPLE_R = offerR;
          iSAMPLE_VALID = 1'b1;
        end
        if (offer && p == 0 && i == 3) iSAMPLE_VALID = 1'b0;
      end
      bits = {bits[18:0], oAUD_DATA};
      iBCK = 1'b1;
      repeat (8) @(negedge OSC_CLK);
    end
  endtask

  task automatic doReset(input logic lrLevel);
    iRST = 1'b1;
    iLRCK = lrLevel;
    iBCK = 1'b1;
    iSAMPLE_VALID = 1'b0;
    repeat (3) @(negedge OSC_CLK);
    checkOutput("rst_data", 32'(oAUD_DATA), 32'd0);
    checkOutput("rst_strobe", 32'(oFRAME_STROBE), 32'd0);
    checkOutput("rst_underrun", 32'(oUNDERRUN), 32'd0);
    checkOutput("rst_ready", 32'(oSAMPLE_READY), 32'd1);
    iRST = 1'b0;
    @(negedge OSC_CLK);
  endtask

  initial begin
    @(negedge OSC_CLK);
    doReset(1'b0);

    $display("[TB] basic frame");
    applyStimulus(16'hA5C3, 16'h0F0F);
    checkOutput("ready_after_accept", 32'(oSAMPLE_READY), 32'd0);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("idle_word", 32'(word), 32'h0);
    checkOutput("idle_strobes", 32'(strobeCount), 32'd0);
    sendChannel(1'b0, 20, 1'b0, '0, '0, word);
    checkOutput("left_a5c3", 32'(word), 32'({1'b0, 16'hA5C3, 3'b000}));
    checkOutput("strobe_1", 32'(strobeCount), 32'd1);
    checkOutput("ready_after_xfer", 32'(oSAMPLE_READY), 32'd1);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("right_0f0f", 32'(word), 32'({1'b0, 16'h0F0F, 3'b000}));
    checkOutput("no_underrun", 32'(oUNDERRUN), 32'd0);

    $display("[TB] underrun repeat");
    sendChannel(1'b0, 20, 1'b0, '0, '0, word);
    checkOutput("left_repeat", 32'(word), 32'({1'b0, 16'hA5C3, 3'b000}));
    checkOutput("underrun_set", 32'(oUNDERRUN), 32'd1);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("right_repeat", 32'(word), 32'({1'b0, 16'h0F0F, 3'b000}));
    checkOutput("underrun_sticky", 32'(oUNDERRUN), 32'd1);
    iUNDERRUN_CLR = 1'b1;
    @(negedge OSC_CLK);
    iUNDERRUN_CLR = 1'b0;
    checkOutput("underrun_clr", 32'(oUNDERRUN), 32'd0);

    $display("[TB] valid coincident with left start");
    sendChannel(1'b0, 20, 1'b1, 16'h1234, 16'h8001, word);
    checkOutput("left_old_pair", 32'(word), 32'({1'b0, 16'hA5C3, 3'b000}));
    checkOutput("underrun_coinc", 32'(oUNDERRUN), 32'd1);
    checkOutput("ready_held_low", 32'(oSAMPLE_READY), 32'd0);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("right_old_pair", 32'(word), 32'({1'b0, 16'h0F0F, 3'b000}));
    checkOutput("ready_still_low", 32'(oSAMPLE_READY), 32'd0);
    iUNDERRUN_CLR = 1'b1;
    @(negedge OSC_CLK);
    iUNDERRUN_CLR = 1'b0;
    sendChannel(1'b0, 20, 1'b0, '0, '0, word);
    checkOutput("left_1234", 32'(word), 32'({1'b0, 16'h1234, 3'b000}));
    checkOutput("underrun_clean", 32'(oUNDERRUN), 32'd0);
    checkOutput("ready_back", 32'(oSAMPLE_READY), 32'd1);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("right_8001", 32'(word), 32'({1'b0, 16'h8001, 3'b000}));

    $display("[TB] LRCK high at reset release");
    doReset(1'b1);
    applyStimulus(16'hCAFE, 16'h0123);
    strobeBase = strobeCount;
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("ignored_rise_word", 32'(word), 32'h0);
    checkOutput("ignored_rise_strobe", 32'(strobeCount - strobeBase), 32'd0);
    sendChannel(1'b0, 20, 1'b0, '0, '0, word);
    checkOutput("left_cafe", 32'(word), 32'({1'b0, 16'hCAFE, 3'b000}));
    checkOutput("first_strobe", 32'(strobeCount - strobeBase), 32'd1);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("right_0123", 32'(word), 32'({1'b0, 16'h0123, 3'b000}));

    $display("[TB] reset mid-frame");
    applyStimulus(16'hFFFF, 16'hFFFF);
    sendChannel(1'b0, 8, 1'b0, '0, '0, word);
    checkOutput("partial_left", 32'(word), 32'h0007F);
    applyStimulus(16'h1111, 16'h2222);
    checkOutput("ready_before_rst", 32'(oSAMPLE_READY), 32'd0);
    iRST = 1'b1;
    @(negedge OSC_CLK);
    checkOutput("midrst_data", 32'(oAUD_DATA), 32'd0);
    checkOutput("midrst_ready", 32'(oSAMPLE_READY), 32'd1);
    checkOutput("midrst_underrun", 32'(oUNDERRUN), 32'd0);
    checkOutput("midrst_strobe", 32'(oFRAME_STROBE), 32'd0);
    repeat (2) @(negedge OSC_CLK);
    iRST = 1'b0;
    @(negedge OSC_CLK);
    applyStimulus(16'h3C3C, 16'hC3C3);
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("post_rst_idle", 32'(word), 32'h0);
    sendChannel(1'b0, 20, 1'b0, '0, '0, word);
    checkOutput("left_3c3c", 32'(word), 32'({1'b0, 16'h3C3C, 3'b000}));
    sendChannel(1'b1, 20, 1'b0, '0, '0, word);
    checkOutput("right_c3c3", 32'(word), 32'({1'b0, 16'hC3C3, 3'b000}));
    checkOutput("final_underrun", 32'(oUNDERRUN), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
